circular_range_counter: RTL

Parametrised circular counter that steps through an arbitrary inclusive range `[min, max]`. It counts up or down by a programmable step, supports a synchronous load, and emits a registered wrap pulse. It generalises the fixed 0..max, step-1, up-only circular counter used in control paths. Typical uses are address rotation, round-robin pointers and strided index generation.

---
 rtl/circular_range_counter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/circular_range_counter.sv
// circular_range_counter
//   Circular counter over an inclusive range [min, max]. It steps up or down by
//   a programmable amount, has a synchronous load and a registered wrap pulse.
//   Optional feature macro: CIRCULAR_COUNTER_WRAP_COUNT_EN adds a saturating
//   wrap_count output that is cleared by reset and by load.
//   rst is synchronous and active-low.
module circular_range_counter #(
    parameter int WIDTH       = 4,
    parameter int STEP_WIDTH  = WIDTH,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   up,
    input  logic [WIDTH-1:0]       min,
    input  logic [WIDTH-1:0]       max,
    input  logic [STEP_WIDTH-1:0]  step,
    input  logic                   load,
    input  logic [WIDTH-1:0]       load_value,
`ifdef CIRCULAR_COUNTER_WRAP_COUNT_EN
    output logic [COUNT_WIDTH-1:0] wrap_count,
`endif
    output logic [WIDTH-1:0]       out,
    output logic                   wrap
);

    logic [WIDTH-1:0] r_out;
    logic             r_wrap;
    logic [WIDTH-1:0] w_out_next;
    logic             w_wrap_next;

    // One extra bit on every operand: out+step and min+step can never overflow.
    logic [WIDTH:0]   w_out_ext;
    logic [WIDTH:0]   w_min_ext;
    logic [WIDTH:0]   w_max_ext;
    logic [WIDTH:0]   w_step_ext;
    logic [WIDTH:0]   w_sum_up;
    logic [WIDTH:0]   w_min_plus_step;
    logic [WIDTH:0]   w_diff_down;
    logic             w_advance;

    assign w_out_ext       = {1'b0, r_out};
    assign w_min_ext       = {1'b0, min};
    assign w_max_ext       = {1'b0, max};
    assign w_step_ext      = (WIDTH+1)'(step);
    assign w_sum_up        = w_out_ext + w_step_ext;
    assign w_min_plus_step = w_min_ext + w_step_ext;
    assign w_diff_down     = w_out_ext - w_step_ext;

    // A step happens only with a non-zero step and a valid range (min <= max).
    assign w_advance = enable && (step != '0) && (max >= min);

    // Next count and wrap flag. Load has priority over stepping. Out-of-range
    // values re-enter the range at the bound nearest the direction of travel.
    always_comb begin
        w_out_next  = r_out;
        w_wrap_next = 1'b0;
        if (load) begin
            w_out_next = load_value;
        end else if (w_advance) begin
            if (up) begin
                if (r_out < min) begin
                    w_out_next = min;
                end else if (w_sum_up > w_max_ext) begin
                    w_out_next  = min;
                    w_wrap_next = 1'b1;
                end else begin
                    w_out_next = w_sum_up[WIDTH-1:0];
                end
            end else begin
                if (r_out > max) begin
                    w_out_next = max;
                end else if (w_out_ext < w_min_plus_step) begin
                    w_out_next  = max;
                    w_wrap_next = 1'b1;
                end else begin
                    w_out_next = w_diff_down[WIDTH-1:0];
                end
            end
        end
    end

    // Count and wrap registers. Reset overrides load and enable.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_out  <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_out  <= w_out_next;
            r_wrap <= w_wrap_next;
        end
    end

    assign out  = r_out;
    assign wrap = r_wrap;

`ifdef CIRCULAR_COUNTER_WRAP_COUNT_EN
    logic [COUNT_WIDTH-1:0] r_wrap_count;

    // Saturating count of wraps; it moves on the same edge that sets wrap.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wrap_count <= '0;
        end else if (load) begin
            r_wrap_count <= '0;
        end else if (w_wrap_next && (r_wrap_count != '1)) begin
            r_wrap_count <= r_wrap_count + 1'b1;
        end
    end

    assign wrap_count = r_wrap_count;
`else
    // COUNT_WIDTH only sizes the optional counter; referenced here so a
    // build without the counter still elaborates the parameter.
    if (COUNT_WIDTH < 1) begin : g_no_wrap_count
    end
`endif

endmodule
